// File: rtl/apb_arb_pkg.sv
// ----------------------------------------------------------------------------
// apb_arb_pkg: shared types and helpers for the APB master arbiter
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_arb_state_e;

  // Counter must be able to hold TIMEOUT_CYCLES itself; never narrower than 1 bit.
  function automatic int tmo_cnt_width(input int timeout_cycles);
    return (timeout_cycles < 1) ? 1 : $clog2(timeout_cycles + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick: combinational round-robin picker, search starts just after `last`
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_pick #(
  parameter int NB_REQ = 4,
  parameter int IDX_W  = $clog2(NB_REQ)
) (
  input  logic [NB_REQ-1:0] req,
  input  logic [IDX_W-1:0]  last,
  output logic [NB_REQ-1:0] gnt,
  output logic [IDX_W-1:0]  idx,
  output logic              valid
);

  logic [IDX_W:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NB_REQ; i++) begin
      cand = {1'b0, last} + (IDX_W + 1)'(i);
      if (cand >= (IDX_W + 1)'(NB_REQ)) begin
        cand = cand - (IDX_W + 1)'(NB_REQ);
      end
      if (!valid && req[cand[IDX_W-1:0]]) begin
        valid                 = 1'b1;
        idx                   = cand[IDX_W-1:0];
        gnt[cand[IDX_W-1:0]]  = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/apb_master_arbiter.sv
// ----------------------------------------------------------------------------
// apb_master_arbiter: round-robin sharing of one APB master port with timeout
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NB_REQ         = 4,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NB_REQ-1:0]                       req_i,
  input  logic [NB_REQ-1:0][APB_ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NB_REQ-1:0][APB_DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [NB_REQ-1:0]                       req_write_i,
  output logic [NB_REQ-1:0]                       gnt_o,
  output logic [NB_REQ-1:0]                       rsp_valid_o,
  output logic [APB_DATA_WIDTH-1:0]               rsp_rdata_o,
  output logic                                    rsp_err_o,
  output logic [APB_ADDR_WIDTH-1:0]               paddr_o,
  output logic [APB_DATA_WIDTH-1:0]               pwdata_o,
  output logic                                    pwrite_o,
  output logic                                    psel_o,
  output logic                                    penable_o,
  input  logic [APB_DATA_WIDTH-1:0]               prdata_i,
  input  logic                                    pready_i,
  input  logic                                    pslverr_i
);

  localparam int IDX_W = $clog2(NB_REQ);
  localparam int CNT_W = tmo_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  apb_arb_state_e    state, next_state;
  logic [IDX_W-1:0]  last;
  logic [IDX_W-1:0]  widx;
  logic [CNT_W-1:0]  cnt;
  logic [NB_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_valid;
  logic              timeout_hit;

  rr_pick #(
    .NB_REQ (NB_REQ),
    .IDX_W  (IDX_W)
  ) u_rr_pick (
    .req   (req_i),
    .last  (last),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == TMO_LAST);

  always_comb begin
    next_state = state;
    gnt_o      = '0;
    case (state)
      IDLE: begin
        gnt_o = pick_gnt;
        if (pick_valid) next_state = SETUP;
      end
      SETUP:   next_state = ACCESS;
      ACCESS:  if (pready_i || timeout_hit) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // APB strobes are registered, so they are set on the edge entering each phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last        <= IDX_W'(NB_REQ - 1);
      widx        <= '0;
      cnt         <= '0;
      paddr_o     <= '0;
      pwdata_o    <= '0;
      pwrite_o    <= 1'b0;
      psel_o      <= 1'b0;
      penable_o   <= 1'b0;
      rsp_valid_o <= '0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      state       <= next_state;
      rsp_valid_o <= '0;
      cnt         <= (state == ACCESS) ? cnt + 1'b1 : '0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            last     <= pick_idx;
            widx     <= pick_idx;
            paddr_o  <= req_addr_i[pick_idx];
            pwdata_o <= req_wdata_i[pick_idx];
            pwrite_o <= req_write_i[pick_idx];
            psel_o   <= 1'b1;
          end
        end
        SETUP: penable_o <= 1'b1;
        ACCESS: begin
          if (pready_i || timeout_hit) begin
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            rsp_valid_o <= NB_REQ'(1) << widx;
            // A ready slave wins over a timeout landing on the same cycle.
            rsp_rdata_o <= (pready_i && !pwrite_o) ? prdata_i : '0;
            rsp_err_o   <= pready_i ? pslverr_i : 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Shares one APB master port among `NB_REQ` on-chip requesters, such as the debug unit, a DMA channel and a boot loader. Arbitration is round-robin. The block captures the winning request, runs a standard two-phase APB transfer (SETUP, then ACCESS), waits for `pready` and returns read data and error status to the granted requester. A programmable timeout ends ACCESS phases that hang, so a dead peripheral cannot lock the SoC peripheral bus.

## Interface
Parameters:
- `NB_REQ`, 4: number of requesters, 2..16.
- `APB_ADDR_WIDTH`, 32: APB address width.
- `APB_DATA_WIDTH`, 32: APB data width.
- `TIMEOUT_CYCLES`, 256: maximum ACCESS cycles before forced termination. 0 disables the timeout.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `req_i` in NB_REQ: per-requester transfer request, level.
- `req_addr_i` in NB_REQ×APB_ADDR_WIDTH: per-requester address.
- `req_wdata_i` in NB_REQ×APB_DATA_WIDTH: per-requester write data.
- `req_write_i` in NB_REQ: 1 = write, 0 = read.
- `gnt_o` out NB_REQ: one-hot, one-cycle pulse; payload captured this cycle.
- `rsp_valid_o` out NB_REQ: one-hot, one-cycle completion pulse to the granted requester.
- `rsp_rdata_o` out APB_DATA_WIDTH: read data, shared; valid with `rsp_valid_o`.
- `rsp_err_o` out 1: `pslverr` or timeout; valid with `rsp_valid_o`.
- `paddr_o`, `pwdata_o`, `pwrite_o`, `psel_o`, `penable_o` out: APB master outputs.
- `prdata_i`, `pready_i`, `pslverr_i` in: APB master inputs.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - If any `req_i` bit is set, pick the winner combinationally and pulse `gnt_o[w]`.
  - Register the winner's addr, wdata and write into the APB output registers, plus `w`. Go to SETUP.
  - If no bit is set, stay in IDLE.
- SETUP: `psel_o`=1, `penable_o`=0. Go to ACCESS unconditionally.
- ACCESS:
  - `psel_o`=1, `penable_o`=1; timeout counter increments each cycle.
  - On `pready_i`=1: capture `prdata_i` (reads only; writes return 0) and `pslverr_i`, then go to RESP.
  - On counter = TIMEOUT_CYCLES−1 with `pready_i`=0: go to RESP with err=1 and rdata=0.
- RESP:
  - `psel_o`=`penable_o`=0.
  - Pulse `rsp_valid_o[w]` and drive rdata/err. Go to IDLE.
- Round-robin:
  - `last` holds the index of the last grant.
  - The winner is the first set `req_i` bit at index `last`+1, `last`+2, … with wrap modulo NB_REQ.
  - `last` updates on every grant; reset value is NB_REQ−1, so requester 0 wins first.
- A requester may drop `req_i` or change its payload any time after its `gnt_o`. A request deasserted before grant is simply never granted.
- A requester whose `req_i` is still high in the IDLE after its own RESP is eligible again, but has lowest priority.
- `paddr_o`, `pwdata_o` and `pwrite_o` hold stable from SETUP through the last ACCESS cycle, per APB.
- Reset mid-transfer:
  - Next cycle, state is IDLE and every output is at its reset value.
  - No `rsp_valid_o` is issued for the aborted transfer. The slave sees `psel` drop.

## Timing
- Reset values:
  - `psel_o`, `penable_o`, `pwrite_o` = 0; `paddr_o`, `pwdata_o` = 0.
  - `gnt_o`, `rsp_valid_o` = 0; `rsp_rdata_o` = 0; `rsp_err_o` = 0.
  - `last` = NB_REQ−1; timeout counter = 0.
- Zero-wait-state slave, grant at cycle t: SETUP at t+1, ACCESS at t+2, RESP at t+3, next grant earliest at t+4. Throughput is one transfer per 4 cycles.
- Each wait state adds one cycle.
- Timeout: RESP arrives exactly TIMEOUT_CYCLES ACCESS cycles after entering ACCESS.
- `pready_i`=1 on the final timeout cycle counts as a normal completion, with no timeout error.
- All outputs are registered except `gnt_o`, which is combinational from `req_i`, `last` and state.

## Structure
- Package `apb_arb_pkg`:
  - State enum `apb_arb_state_e`: IDLE, SETUP, ACCESS, RESP.
  - Localparam helper for the timeout counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1.
- Sub-module `rr_pick`: parameterised NB_REQ round-robin picker. Inputs are the request vector and `last`; outputs are the one-hot grant and its index. Purely combinational, so it can be reused by other arbiters.

## Test plan
- Single read, NB_REQ=4, zero-wait slave:
  - Stimulus: `req_i`=0001, addr 0x1A10_1000; slave returns 0xDEAD_BEEF.
  - Required: gnt at t, `psel_o`/`penable_o` at t+1/t+2, `rsp_valid_o`=0001 at t+3 with rdata 0xDEAD_BEEF, err=0.
- All four requesters held high for 8 transfers:
  - Required grant order: 0,1,2,3,0,1,2,3. Each `paddr_o` matches its requester, and `rsp_valid_o` always matches the granted index.
- Wait states plus error:
  - Stimulus: write to 0x1A10_7004, data 0x5; slave inserts 3 wait states, then `pslverr_i`=1.
  - Required: paddr and pwdata stable over all ACCESS cycles, RESP at t+6, `rsp_err_o`=1.
- Timeout, TIMEOUT_CYCLES=8, `pready_i` held 0:
  - Required: exactly 8 ACCESS cycles, then `psel_o` drops, `rsp_valid_o` pulses with err=1 and rdata=0, and the next request is granted normally.
- Reset during ACCESS (`rst`=1 for 1 cycle):
  - Required: next cycle all outputs at reset values and no `rsp_valid_o` pulse.
  - Following request from requester 2 with requester 0 also requesting: requester 0 is granted first, since `last` was reset.
